// File: rtl/sram_like_data_resp_pkg.sv
// Shared types and constants for the SRAM-like data-side responder.
package sram_like_data_resp_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic [2:0]  countdown;
    } resp_entry_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue; every valid entry counts down to zero and the head
// is ready once its countdown reaches zero.
module sram_resp_fifo
    import sram_like_data_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  resp_entry_t   push_entry,
    input  logic          pop,
    output logic          head_ready,
    output resp_entry_t   head_entry,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    resp_entry_t      entry_q [DEPTH];
    resp_entry_t      entry_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && entry_q[i].countdown != 3'd0) begin
                entry_d[i].countdown = entry_q[i].countdown - 3'd1;
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        // A new entry starts at its full countdown; it is not decremented on entry.
        if (push) begin
            entry_d[wr_ptr_q] = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head_entry = entry_q[rd_ptr_q];
    assign head_ready = valid_q[rd_ptr_q] && (head_entry.countdown == 3'd0);
    assign count      = count_q;

endmodule

// File: rtl/sram_like_data_resp.sv
// Responder end of the CPU data-side SRAM-like interface, backed by a word memory.
// Define SRAM_RESP_STALL_EN to add LFSR-driven random stalls on accept and issue.
module sram_like_data_resp
    import sram_like_data_resp_pkg::*;
#(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int unsigned CW = $clog2(OUTSTANDING + 1);

    logic [CW-1:0]     count;
    logic              head_ready;
    resp_entry_t       head_entry;
    resp_entry_t       push_entry;
    logic              accept;
    logic              issue;
    logic              stall_accept;
    logic              stall_issue;
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       mem [2**MEM_AW];
    logic [31:0]       rdata_q;
    logic              unused_bits;

`ifdef SRAM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign stall_accept = lfsr_q[0];
    assign stall_issue  = lfsr_q[1];
`else
    assign stall_accept = 1'b0;
    assign stall_issue  = 1'b0;
`endif

    // Size and the sub-word/alias address bits carry no meaning for a word memory.
    assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:MEM_AW+2]};

    assign word_idx = data_sram_addr[MEM_AW+1:2];

    assign data_sram_addr_ok = resetn && (count < CW'(OUTSTANDING)) && !stall_accept;
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign issue             = head_ready && !stall_issue;

    // Read data is snapshotted at acceptance so later writes cannot disturb it.
    always_comb begin
        push_entry           = '0;
        push_entry.is_read   = !data_sram_wr;
        push_entry.data      = data_sram_wr ? 32'h0 : mem[word_idx];
        push_entry.countdown = 3'(LATENCY - 1);
    end

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    sram_resp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (issue),
        .head_ready (head_ready),
        .head_entry (head_entry),
        .count      (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0;
        end else if (issue) begin
            rdata_q <= head_entry.data;
        end
    end

    assign data_sram_data_ok = issue;
    assign data_sram_rdata   = issue ? head_entry.data : rdata_q;

endmodule

// File: tb/tb_sram_like_data_resp.sv
// Scoreboard bench for sram_like_data_resp with a spec-level timing and memory model.
module tb_sram_like_data_resp;

    localparam int unsigned MEM_AW      = 10;
    localparam int unsigned OUTSTANDING = 2;
    localparam int unsigned LATENCY     = 3;

    logic        clk;
    logic        resetn;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    sram_like_data_resp #(
        .MEM_AW      (MEM_AW),
        .OUTSTANDING (OUTSTANDING),
        .LATENCY     (LATENCY)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        pend[$];
    logic [31:0] mmem [int];
    int          cyc = 0;
    int          acc = 0;
    int          resp = 0;
    bit          exp_addr_ok = 1'b0;
    logic [31:0] last_rdata = 32'h0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Stimulus side: the accepting edge pushes the expected response.
    always @(posedge clk) begin
        int          idx;
        logic [31:0] w;
        if (resetn && data_sram_req && exp_addr_ok) begin
            idx = int'(data_sram_addr[MEM_AW+1:2]);
            if (data_sram_wr) begin
                w = mmem.exists(idx) ? mmem[idx] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (data_sram_wstrb[b]) w[8*b +: 8] = data_sram_wdata[8*b +: 8];
                end
                mmem[idx] = w;
                pend.push_back('{is_read: 1'b0, data: 32'h0, due: cyc + int'(LATENCY)});
            end else begin
                pend.push_back('{is_read: 1'b1, data: mmem[idx], due: cyc + int'(LATENCY)});
            end
            acc++;
        end
        cyc++;
    end

    // Monitor: every cycle compares addr_ok, data_ok and rdata with the model.
    always @(negedge clk) begin
        bit exp_ok;
        exp_addr_ok = resetn && ((acc - resp) < int'(OUTSTANDING));
        exp_ok      = resetn && pend.size() > 0 && pend[0].due <= cyc;
        check("addr_ok", 32'(data_sram_addr_ok), 32'(exp_addr_ok));
        check("data_ok", 32'(data_sram_data_ok), 32'(exp_ok));
        if (!resetn) last_rdata = 32'h0;
        if (data_sram_data_ok && exp_ok) begin
            check("rdata", data_sram_rdata, pend[0].data);
            last_rdata = pend[0].data;
            void'(pend.pop_front());
            resp++;
        end else if (!data_sram_data_ok && !exp_ok) begin
            check("rdata_hold", data_sram_rdata, last_rdata);
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        bit got;
        got             = 1'b0;
        data_sram_req   = 1'b1;
        data_sram_wr    = wr;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        data_sram_wstrb = strb;
        data_sram_size  = 2'($urandom_range(0, 2));
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = data_sram_addr_ok;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout: got no addr_ok, required one within 64 cycles");
        end
        @(posedge clk);
        #1;
        data_sram_req   = 1'b0;
        data_sram_addr  = $urandom;
        data_sram_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample_rdata(input string name, input logic [31:0] want);
        @(negedge clk);
        check(name, data_sram_rdata, want);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] addr;
        int          w;
        resetn          = 1'b1;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'b10;
        data_sram_wstrb = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        idle(6);
        sample_rdata("read_back", 32'hDEADBEEF);
        issue(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        idle(6);
        sample_rdata("partial_write", 32'hDEADABEF);

        // Two reads in flight are discarded by reset; memory survives.
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        resetn = 1'b0;
        pend.delete();
        acc  = 0;
        resp = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(4);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        idle(6);
        sample_rdata("reset_keeps_mem", 32'hDEADABEF);

        for (int i = 0; i < 8; i++) issue(1'b1, 32'(i << 2), $urandom, 4'hF);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF);
        issue(1'b0, 32'h0000, 32'h0, 4'h0);
        idle(6);
        sample_rdata("alias_0000", 32'h12345678);
        issue(1'b0, 32'h1003, 32'h0, 4'h0);
        idle(6);
        sample_rdata("alias_1003", 32'h12345678);

        // Full queue: three held reads, timing checked cycle by cycle by the monitor.
        for (int i = 0; i < 3; i++) issue(1'b0, 32'(i << 2), 32'h0, 4'h0);
        idle(8);

        for (int n = 0; n < 300; n++) begin
            w    = $urandom_range(0, 7);
            addr = ($urandom & 32'hFFFFF000) | 32'(w << 2) | ($urandom & 32'h3);
            issue(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        for (int k = 0; k < 50 && pend.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        check("drained", 32'(pend.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
